// File: rtl/decade_down_timer_pkg.sv
// Shared types and constants for the BCD down-timer: FSM state encoding,
// BCD digit width/limit, and the load-value clamp applied per digit.
package decade_pkg;

  localparam int          BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Non-decimal nibbles (A..F) are forced to 9 so the counter never holds an illegal digit.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/decade_down_timer_if.sv
// Control/status bundle of the down-timer; master drives the controls,
// slave (the timer) returns count and status.
interface decade_down_timer_if
  import decade_pkg::*;
#(
  parameter int DIGITS = 2
);

  logic                      load;
  logic [BCD_W*DIGITS-1:0]   load_val;
  logic                      start;
  logic                      pause;
  logic [BCD_W*DIGITS-1:0]   count;
  logic                      busy;
  logic                      zero;
  logic                      done;

  modport master (
    output load, load_val, start, pause,
    input  count, busy, zero, done
  );

  modport slave (
    input  load, load_val, start, pause,
    output count, busy, zero, done
  );

endinterface

// File: rtl/decade_down_timer_digit.sv
// One BCD digit of the down-timer: clamped load, decrement with 0 -> 9 wrap.
module bcd_digit_down
  import decade_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             dec_en,
  output logic [BCD_W-1:0] digit,
  output logic             is_zero
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (ld) begin
      digit_d = bcd_clamp(ld_val);
    end else if (dec_en) begin
      digit_d = (digit_q == '0) ? BCD_MAX : (digit_q - 4'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit   = digit_q;
  assign is_zero = (digit_q == '0);

endmodule

// File: rtl/decade_down_timer.sv
// Multi-digit BCD countdown timer with load/start/pause control and a
// one-cycle done pulse; FSM here, per-digit arithmetic in bcd_digit_down.
module decade_down_timer
  import decade_pkg::*;
#(
  parameter int DIGITS = 2
)(
  input  logic               clk,
  input  logic               rst_n,
  decade_down_timer_if.slave bus
);

  state_e                    state_q;
  state_e                    state_d;
  logic                      busy_q;
  logic                      done_q;
  logic [BCD_W*DIGITS-1:0]   count;
  logic [DIGITS-1:0]         dig_zero;
  logic [DIGITS-1:0]         dec_en;
  logic                      all_zero;
  logic                      run_dec;
  logic                      lower_zero;

  assign all_zero = &dig_zero;

  // RUN leaves for DONE on the cycle after zero is reached, so zero itself never decrements.
  assign run_dec = (state_q == RUN) && !bus.load && !bus.pause && !all_zero;

  always_comb begin
    lower_zero = 1'b1;
    dec_en     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dec_en[i]  = run_dec & lower_zero;
      lower_zero = lower_zero & dig_zero[i];
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = all_zero ? DONE : RUN;
          end
        end
        RUN: begin
          if (bus.pause) begin
            state_d = PAUSED;
          end else if (all_zero) begin
            state_d = DONE;
          end
        end
        PAUSED: begin
          if (bus.start) begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN) || (state_d == PAUSED);
      done_q  <= (state_d == DONE);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_down u_digit (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld      (bus.load),
      .ld_val  (bus.load_val[g*BCD_W +: BCD_W]),
      .dec_en  (dec_en[g]),
      .digit   (count[g*BCD_W +: BCD_W]),
      .is_zero (dig_zero[g])
    );
  end

  assign bus.count = count;
  assign bus.busy  = busy_q;
  assign bus.zero  = all_zero;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_decade_down_timer.sv
// Directed bench for decade_down_timer: a 2-digit instance for most scenarios
// and a 3-digit instance for the borrow chain.
module tb_decade_down_timer;

  logic clk;
  logic rst_n;
  int   total;
  int   fails;
  int   v;

  decade_down_timer_if #(.DIGITS(2)) i2 ();
  decade_down_timer_if #(.DIGITS(3)) i3 ();

  decade_down_timer #(.DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(i2));
  decade_down_timer #(.DIGITS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(i3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    fails = 0;
    rst_n = 1'b0;
    i2.load = 1'b0; i2.load_val = '0; i2.start = 1'b0; i2.pause = 1'b0;
    i3.load = 1'b0; i3.load_val = '0; i3.start = 1'b0; i3.pause = 1'b0;

    // Reset state
    #3;
    chk("rst_count", 16'(i2.count), 16'h00);
    chk("rst_zero",  16'(i2.zero),  16'h1);
    chk("rst_busy",  16'(i2.busy),  16'h0);
    chk("rst_done",  16'(i2.done),  16'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic countdown from 12
    i2.load = 1'b1; i2.load_val = 8'h12;
    tick();
    i2.load = 1'b0;
    chk("load12_count", 16'(i2.count), 16'h12);
    chk("load12_zero",  16'(i2.zero),  16'h0);
    chk("load12_busy",  16'(i2.busy),  16'h0);
    i2.start = 1'b1;
    tick();
    i2.start = 1'b0;
    chk("start_edge_count", 16'(i2.count), 16'h12);
    chk("start_edge_busy",  16'(i2.busy),  16'h1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      v = 12 - k;
      chk("countdown", 16'(i2.count), 16'(((v / 10) << 4) | (v % 10)));
      chk("countdown_done", 16'(i2.done), 16'h0);
    end
    chk("at_zero_zero", 16'(i2.zero), 16'h1);
    chk("at_zero_busy", 16'(i2.busy), 16'h1);
    tick();
    chk("done_pulse",      16'(i2.done),  16'h1);
    chk("done_count",      16'(i2.count), 16'h00);
    chk("done_busy",       16'(i2.busy),  16'h0);
    tick();
    chk("done_one_cycle",  16'(i2.done),  16'h0);
    chk("post_done_count", 16'(i2.count), 16'h00);

    // Pause / resume from 05
    i2.load = 1'b1; i2.load_val = 8'h05;
    tick();
    i2.load = 1'b0;
    i2.start = 1'b1;
    tick();
    i2.start = 1'b0;
    tick();
    chk("p_04", 16'(i2.count), 16'h04);
    tick();
    chk("p_03", 16'(i2.count), 16'h03);
    i2.pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("paused_hold", 16'(i2.count), 16'h03);
      chk("paused_busy", 16'(i2.busy),  16'h1);
    end
    i2.pause = 1'b0;
    i2.start = 1'b1;
    tick();
    i2.start = 1'b0;
    chk("resume_edge", 16'(i2.count), 16'h03);
    tick();
    chk("resume_02", 16'(i2.count), 16'h02);
    tick();
    chk("resume_01", 16'(i2.count), 16'h01);
    tick();
    chk("resume_00", 16'(i2.count), 16'h00);
    chk("resume_00_done", 16'(i2.done), 16'h0);
    tick();
    chk("resume_done", 16'(i2.done), 16'h1);

    // Clamp on load
    i2.load = 1'b1; i2.load_val = 8'hA7;
    tick();
    i2.load = 1'b0;
    chk("clamp_A7", 16'(i2.count), 16'h97);
    i2.load = 1'b1; i2.load_val = 8'hFC;
    tick();
    i2.load = 1'b0;
    chk("clamp_FC", 16'(i2.count), 16'h99);

    // Start from zero
    i2.load = 1'b1; i2.load_val = 8'h00;
    tick();
    i2.load = 1'b0;
    i2.start = 1'b1;
    tick();
    i2.start = 1'b0;
    chk("zstart_done",  16'(i2.done),  16'h1);
    chk("zstart_count", 16'(i2.count), 16'h00);
    chk("zstart_busy",  16'(i2.busy),  16'h0);
    tick();
    chk("zstart_nowrap", 16'(i2.count), 16'h00);
    chk("zstart_done_clr", 16'(i2.done), 16'h0);

    // Load override while running
    i2.load = 1'b1; i2.load_val = 8'h20;
    tick();
    i2.load = 1'b0;
    i2.start = 1'b1;
    tick();
    i2.start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("ovr_15", 16'(i2.count), 16'h15);
    i2.load = 1'b1; i2.load_val = 8'h08;
    tick();
    i2.load = 1'b0;
    chk("ovr_count", 16'(i2.count), 16'h08);
    chk("ovr_busy",  16'(i2.busy),  16'h0);
    chk("ovr_done",  16'(i2.done),  16'h0);
    tick();
    tick();
    chk("ovr_idle_hold", 16'(i2.count), 16'h08);
    chk("ovr_idle_done", 16'(i2.done),  16'h0);

    // Borrow chain on the 3-digit instance
    i3.load = 1'b1; i3.load_val = 12'h100;
    tick();
    i3.load = 1'b0;
    i3.start = 1'b1;
    tick();
    i3.start = 1'b0;
    chk("b3_100", 16'(i3.count), 16'h100);
    tick();
    chk("b3_099", 16'(i3.count), 16'h099);
    tick();
    chk("b3_098", 16'(i3.count), 16'h098);

    // Asynchronous reset mid-count from 37
    i2.load = 1'b1; i2.load_val = 8'h37;
    tick();
    i2.load = 1'b0;
    i2.start = 1'b1;
    tick();
    i2.start = 1'b0;
    tick();
    tick();
    chk("r37_35", 16'(i2.count), 16'h35);
    rst_n = 1'b0;
    #2;
    chk("arst_count", 16'(i2.count), 16'h00);
    chk("arst_zero",  16'(i2.zero),  16'h1);
    chk("arst_busy",  16'(i2.busy),  16'h0);
    chk("arst_b3",    16'(i3.count), 16'h000);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_count", 16'(i2.count), 16'h00);
    chk("post_rst_busy",  16'(i2.busy),  16'h0);
    chk("post_rst_done",  16'(i2.done),  16'h0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
